bridge_arbiter: RTL and testbench

Two-requester arbiter sharing the single `bridge` request/response channel (and thus pseudo-DRAM) between the BEV core (port 0) and a maintenance/refill client (port 1). It latches each client's single-cycle request pulse into a one-entry slot and issues one bridge transaction at a time. Simultaneous pending requests are granted round-robin. Each response is routed back to its owner, and a watchdog aborts transactions the bridge never completes.

---
 rtl/bridge_arbiter_pkg.sv | 24 ++
 rtl/bridge_arbiter_arb_slot.sv | 39 +++
 rtl/bridge_arbiter.sv | 121 ++++++++++++
 tb/tb_bridge_arbiter.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bridge_arbiter_pkg.sv
// Shared types and helpers for the two-client bridge arbiter.
// Holds the FSM state encodings, the request record and the grant picker.
package bridge_arbiter_pkg;

  localparam int ARB_CLIENTS = 2;

  typedef logic [1:0] Arb_state;
  localparam Arb_state ARB_IDLE  = 2'd0;
  localparam Arb_state ARB_ISSUE = 2'd1;
  localparam Arb_state ARB_WAIT  = 2'd2;
  localparam Arb_state ARB_RESP  = 2'd3;

  typedef struct packed {
    logic        r_wb;
    logic [7:0]  addr;
    logic [63:0] wdata;
  } Arb_req;

  // With both slots pending the round-robin pointer decides, otherwise the lone requester wins.
  function automatic logic pick_grant(input logic [1:0] pending, input logic rr_ptr);
    return (pending == 2'b11) ? rr_ptr : pending[1];
  endfunction

endpackage

// File: rtl/bridge_arbiter_arb_slot.sv
// One-entry request holder: latches a client's request pulse while empty.
// A pulse arriving while the slot is full is dropped; the slot keeps its contents.
module arb_slot #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              load_r_wb,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_wdata,
  input  logic              clear,
  output logic              valid,
  output logic              ready,
  output logic              r_wb,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wdata
);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      r_wb  <= 1'b0;
      addr  <= '0;
      wdata <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load && !valid) begin
      valid <= 1'b1;
      r_wb  <= load_r_wb;
      addr  <= load_addr;
      wdata <= load_wdata;
    end
  end

  assign ready = ~valid;

endmodule

// File: rtl/bridge_arbiter.sv
// Shares the single bridge channel between the BEV core (port 0) and a refill client (port 1).
// One transaction in flight at a time, round-robin on contention, watchdog abort on silence.
module bridge_arbiter
  import bridge_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 1023
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [ARB_CLIENTS-1:0]               req_valid,
  input  logic [ARB_CLIENTS-1:0]               req_r_wb,
  input  logic [ARB_CLIENTS-1:0][ADDR_W-1:0]   req_addr,
  input  logic [ARB_CLIENTS-1:0][DATA_W-1:0]   req_wdata,
  output logic [ARB_CLIENTS-1:0]               req_ready,
  output logic [ARB_CLIENTS-1:0]               rsp_valid,
  output logic [DATA_W-1:0]                    rsp_rdata,
  output logic [ARB_CLIENTS-1:0]               rsp_err,
  output logic                                 C_in_valid,
  output logic                                 C_r_wb,
  output logic [ADDR_W-1:0]                    C_addr,
  output logic [DATA_W-1:0]                    C_data_w,
  input  logic                                 C_out_valid,
  input  logic [DATA_W-1:0]                    C_data_r
);

  localparam logic [12:0] TIMEOUT_LIM = 13'(TIMEOUT);

  Arb_state                              state;
  logic                                  grant;
  logic                                  rr_ptr;
  logic                                  err;
  logic [11:0]                           wd_cnt;
  logic [ARB_CLIENTS-1:0]                slot_v;
  logic [ARB_CLIENTS-1:0]                slot_rwb;
  logic [ARB_CLIENTS-1:0][ADDR_W-1:0]    slot_addr;
  logic [ARB_CLIENTS-1:0][DATA_W-1:0]    slot_wdata;
  logic [ARB_CLIENTS-1:0]                slot_clear;
  logic                                  next_grant;

  assign slot_clear = (state == ARB_RESP) ? (grant ? 2'b10 : 2'b01) : 2'b00;
  assign next_grant = pick_grant(slot_v, rr_ptr);

  for (genvar i = 0; i < ARB_CLIENTS; i++) begin : g_slot
    arb_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_slot (
      .clk        (clk),
      .rst        (rst),
      .load       (req_valid[i]),
      .load_r_wb  (req_r_wb[i]),
      .load_addr  (req_addr[i]),
      .load_wdata (req_wdata[i]),
      .clear      (slot_clear[i]),
      .valid      (slot_v[i]),
      .ready      (req_ready[i]),
      .r_wb       (slot_rwb[i]),
      .addr       (slot_addr[i]),
      .wdata      (slot_wdata[i])
    );
  end

  // Bridge fields are registered at grant time so they hold the last issued request afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ARB_IDLE;
      grant     <= 1'b0;
      rr_ptr    <= 1'b0;
      err       <= 1'b0;
      wd_cnt    <= '0;
      C_r_wb    <= 1'b0;
      C_addr    <= '0;
      C_data_w  <= '0;
      rsp_rdata <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (|slot_v) begin
            grant    <= next_grant;
            C_r_wb   <= slot_rwb[next_grant];
            C_addr   <= slot_addr[next_grant];
            C_data_w <= slot_wdata[next_grant];
            state    <= ARB_ISSUE;
          end
        end
        ARB_ISSUE: begin
          wd_cnt <= '0;
          state  <= ARB_WAIT;
        end
        ARB_WAIT: begin
          if (C_out_valid) begin
            err       <= 1'b0;
            rsp_rdata <= C_r_wb ? C_data_r : '0;
            state     <= ARB_RESP;
          end else if (({1'b0, wd_cnt} + 13'd1) >= TIMEOUT_LIM) begin
            err       <= 1'b1;
            rsp_rdata <= '0;
            state     <= ARB_RESP;
          end else if (wd_cnt != 12'hFFF) begin
            wd_cnt <= wd_cnt + 12'd1;
          end
        end
        default: begin
          rr_ptr <= ~grant;
          state  <= ARB_IDLE;
        end
      endcase
    end
  end

  assign C_in_valid = (state == ARB_ISSUE);

  always_comb begin
    rsp_valid = '0;
    rsp_err   = '0;
    if (state == ARB_RESP) begin
      if (err) rsp_err[grant] = 1'b1;
      else     rsp_valid[grant] = 1'b1;
    end
  end

endmodule

// File: tb/tb_bridge_arbiter.sv
// Self-checking bench for bridge_arbiter: directed scenarios then random traffic,
// compared every cycle against a transaction-timeline reference model.
module tb_bridge_arbiter;

  localparam int TO = 20;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [1:0]       req_valid = '0;
  logic [1:0]       req_r_wb = '0;
  logic [1:0][7:0]  req_addr = '0;
  logic [1:0][63:0] req_wdata = '0;
  logic [1:0]       req_ready;
  logic [1:0]       rsp_valid;
  logic [63:0]      rsp_rdata;
  logic [1:0]       rsp_err;
  logic             C_in_valid;
  logic             C_r_wb;
  logic [7:0]       C_addr;
  logic [63:0]      C_data_w;
  logic             C_out_valid = 1'b0;
  logic [63:0]      C_data_r = '0;

  bridge_arbiter #(.ADDR_W(8), .DATA_W(64), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_r_wb    (req_r_wb),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .C_in_valid  (C_in_valid),
    .C_r_wb      (C_r_wb),
    .C_addr      (C_addr),
    .C_data_w    (C_data_w),
    .C_out_valid (C_out_valid),
    .C_data_r    (C_data_r)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit checking = 1'b0;

  // Stimulus requested for the next cycle
  bit               drv_rst = 1'b0;
  logic [1:0]       drv_valid = '0;
  logic [1:0]       drv_rwb = '0;
  logic [1:0][7:0]  drv_addr = '0;
  logic [1:0][63:0] drv_wdata = '0;

  // Bridge behaviour for the next granted transaction
  bit          plan_random = 1'b0;
  int          plan_lat = 1;
  logic [63:0] plan_data = '0;
  int          br_cyc = -1;
  logic [63:0] br_data = '0;

  // Reference model: pending slots plus the timeline of the transaction in flight
  bit          m_v[2];
  bit          m_rwb[2];
  logic [7:0]  m_addr[2];
  logic [63:0] m_wdata[2];
  bit          busy = 1'b0;
  int          tg = 0;
  int          rr = 0;
  int          issue_c = 0;
  int          resp_c = 0;
  bit          t_err = 1'b0;
  logic [63:0] t_rdata = '0;
  bit          e_rwb = 1'b0;
  logic [7:0]  e_addr = '0;
  logic [63:0] e_wdata = '0;
  logic [63:0] e_rdata = '0;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, observed, expected);
    end
  endtask

  task automatic modelReset();
    m_v[0] = 1'b0;
    m_v[1] = 1'b0;
    busy = 1'b0;
    rr = 0;
    e_rwb = 1'b0;
    e_addr = '0;
    e_wdata = '0;
    e_rdata = '0;
  endtask

  // One clock cycle: check outputs, drive inputs, advance the model.
  task automatic applyStimulus();
    logic [1:0] ev;
    logic [1:0] ee;
    bit do_clear;
    @(negedge clk);
    ev = '0;
    ee = '0;
    if (busy && cyc == resp_c) begin
      e_rdata = t_rdata;
      if (t_err) ee[tg] = 1'b1;
      else       ev[tg] = 1'b1;
    end
    if (checking) begin
      checkOutput("req_ready", 64'(req_ready), 64'({~m_v[1], ~m_v[0]}));
      checkOutput("rsp_valid", 64'(rsp_valid), 64'(ev));
      checkOutput("rsp_err", 64'(rsp_err), 64'(ee));
      checkOutput("rsp_rdata", rsp_rdata, e_rdata);
      checkOutput("C_in_valid", 64'(C_in_valid), 64'(busy && cyc == issue_c));
      checkOutput("C_r_wb", 64'(C_r_wb), 64'(e_rwb));
      checkOutput("C_addr", 64'(C_addr), 64'(e_addr));
      checkOutput("C_data_w", C_data_w, e_wdata);
    end

    rst = drv_rst;
    req_valid = drv_valid;
    req_r_wb = drv_rwb;
    req_addr = drv_addr;
    req_wdata = drv_wdata;
    C_out_valid = (cyc == br_cyc);
    C_data_r = (cyc == br_cyc) ? br_data : {$urandom, $urandom};

    if (drv_rst) begin
      modelReset();
      checking = 1'b1;
    end else begin
      do_clear = busy && cyc == resp_c;
      if (!busy && (m_v[0] || m_v[1])) begin
        tg = (m_v[0] && m_v[1]) ? rr : (m_v[1] ? 1 : 0);
        busy = 1'b1;
        issue_c = cyc + 1;
        e_rwb = m_rwb[tg];
        e_addr = m_addr[tg];
        e_wdata = m_wdata[tg];
        if (plan_random) begin
          plan_lat = ($urandom_range(0, 9) == 0) ? $urandom_range(TO - 2, TO + 5) : $urandom_range(1, 12);
          plan_data = {$urandom, $urandom};
        end
        br_data = plan_data;
        if (plan_lat <= TO) begin
          br_cyc = issue_c + plan_lat;
          resp_c = br_cyc + 1;
          t_err = 1'b0;
          t_rdata = e_rwb ? plan_data : 64'd0;
        end else begin
          br_cyc = (plan_lat <= TO + 3) ? issue_c + plan_lat : -1;
          resp_c = issue_c + TO + 1;
          t_err = 1'b1;
          t_rdata = 64'd0;
        end
      end
      for (int i = 0; i < 2; i++) begin
        if (drv_valid[i] && !m_v[i]) begin
          m_v[i] = 1'b1;
          m_rwb[i] = drv_rwb[i];
          m_addr[i] = drv_addr[i];
          m_wdata[i] = drv_wdata[i];
        end
      end
      if (do_clear) begin
        m_v[tg] = 1'b0;
        rr = 1 - tg;
        busy = 1'b0;
      end
    end
    drv_rst = 1'b0;
    drv_valid = '0;
    cyc++;
  endtask

  task automatic runIdle(input int n);
    for (int k = 0; k < n; k++) applyStimulus();
  endtask

  task automatic setReq(input int c, input bit rwb, input logic [7:0] addr, input logic [63:0] wdata);
    drv_valid[c] = 1'b1;
    drv_rwb[c] = rwb;
    drv_addr[c] = addr;
    drv_wdata[c] = wdata;
  endtask

  initial begin
    drv_rst = 1'b1;
    applyStimulus();
    drv_rst = 1'b1;
    applyStimulus();
    runIdle(3);

    // Single read on port 0 answered after 10 cycles
    plan_lat = 10;
    plan_data = 64'hDEAD_BEEF_0000_1234;
    setReq(0, 1'b1, 8'h05, {$urandom, $urandom});
    applyStimulus();
    runIdle(18);

    // Simultaneous pair, twice
    plan_lat = 4;
    plan_data = {$urandom, $urandom};
    setReq(0, 1'b1, 8'h01, {$urandom, $urandom});
    setReq(1, 1'b0, 8'h02, 64'h0123_4567_89AB_CDEF);
    applyStimulus();
    runIdle(20);
    setReq(0, 1'b0, 8'h11, {$urandom, $urandom});
    setReq(1, 1'b1, 8'h22, {$urandom, $urandom});
    applyStimulus();
    runIdle(20);

    // Back-to-back: P1 arrives during P0's wait, a second P0 pulse is dropped
    plan_lat = 8;
    plan_data = {$urandom, $urandom};
    setReq(0, 1'b1, 8'h30, {$urandom, $urandom});
    applyStimulus();
    runIdle(4);
    setReq(1, 1'b1, 8'h31, {$urandom, $urandom});
    applyStimulus();
    setReq(0, 1'b0, 8'h3F, {$urandom, $urandom});
    applyStimulus();
    runIdle(25);

    // Silent bridge, then a late completion that must be ignored
    plan_lat = TO + 2;
    plan_data = {$urandom, $urandom};
    setReq(0, 1'b1, 8'h40, {$urandom, $urandom});
    applyStimulus();
    runIdle(30);

    // Write completion on port 1
    plan_lat = 5;
    plan_data = {$urandom, $urandom};
    setReq(1, 1'b0, 8'h33, {$urandom, $urandom});
    applyStimulus();
    runIdle(12);

    // Reset during WAIT discards everything, including a pulse in the reset cycle
    plan_lat = 15;
    setReq(0, 1'b1, 8'h50, {$urandom, $urandom});
    applyStimulus();
    runIdle(5);
    setReq(1, 1'b1, 8'h51, {$urandom, $urandom});
    drv_rst = 1'b1;
    applyStimulus();
    runIdle(30);

    // Random traffic, including pulses against full slots
    plan_random = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 2; i++) begin
        if ($urandom_range(0, 5) == 0) setReq(i, 1'($urandom), 8'($urandom), {$urandom, $urandom});
      end
      applyStimulus();
    end
    runIdle(40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
